// File: rtl/merge_2x1_fifo.sv
// merge_2x1_fifo: two lane FIFOs merged by a round-robin arbiter into one registered valid/ready stream.
// Ports: clk, reset (async, active-high); data_in0/valid_in0 and data_in1/valid_in1 lane writes;
// full0/full1 registered full flags; data_out/valid_out merged output; ready_in downstream accept.
// Optional: MERGE_OVF_FLAG_EN adds sticky overflow flags ovf0/ovf1.
module merge_2x1_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in0,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  output logic             full0,
  output logic             full1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in
`ifdef MERGE_OVF_FLAG_EN
  ,
  output logic             ovf0,
  output logic             ovf1
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem0 [DEPTH];
  logic [WIDTH-1:0] r_mem1 [DEPTH];
  logic [AW-1:0] r_wp0, r_rp0, r_wp1, r_rp1;
  logic [AW:0] r_cnt0, r_cnt1;
  logic r_full0, r_full1, r_last, r_valid;
  logic [WIDTH-1:0] r_data;
  logic w_push0, w_push1, w_ne0, w_ne1, w_free, w_pop, w_sel, w_pop0, w_pop1;
  logic [AW:0] w_cnt0, w_cnt1;
  assign w_push0 = valid_in0 && !r_full0;
  assign w_push1 = valid_in1 && !r_full1;
  assign w_ne0 = r_cnt0 != '0;
  assign w_ne1 = r_cnt1 != '0;
  assign w_free = !r_valid || ready_in;
  assign w_pop = w_free && (w_ne0 || w_ne1);
  // with both lanes pending, serve the one not served last
  assign w_sel = (w_ne0 && w_ne1) ? !r_last : w_ne1;
  assign w_pop0 = w_pop && !w_sel;
  assign w_pop1 = w_pop && w_sel;
  assign w_cnt0 = r_cnt0 + (AW+1)'(w_push0) - (AW+1)'(w_pop0);
  assign w_cnt1 = r_cnt1 + (AW+1)'(w_push1) - (AW+1)'(w_pop1);
  always_ff @(posedge clk) begin
    if (w_push0) r_mem0[r_wp0] <= data_in0;
    if (w_push1) r_mem1[r_wp1] <= data_in1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp0 <= '0;
      r_rp0 <= '0;
      r_wp1 <= '0;
      r_rp1 <= '0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_full0 <= 1'b0;
      r_full1 <= 1'b0;
      r_last <= 1'b1;
      r_valid <= 1'b0;
      r_data <= '0;
    end else begin
      r_cnt0 <= w_cnt0;
      r_cnt1 <= w_cnt1;
      r_full0 <= w_cnt0 == (AW+1)'(DEPTH);
      r_full1 <= w_cnt1 == (AW+1)'(DEPTH);
      if (w_push0) r_wp0 <= r_wp0 + 1'b1;
      if (w_push1) r_wp1 <= r_wp1 + 1'b1;
      if (w_pop0) r_rp0 <= r_rp0 + 1'b1;
      if (w_pop1) r_rp1 <= r_rp1 + 1'b1;
      if (w_pop) begin
        r_data <= w_sel ? r_mem1[r_rp1] : r_mem0[r_rp0];
        r_valid <= 1'b1;
        r_last <= w_sel;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign full0 = r_full0;
  assign full1 = r_full1;
  assign data_out = r_data;
  assign valid_out = r_valid;
`ifdef MERGE_OVF_FLAG_EN
  logic r_ovf0, r_ovf1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf0 <= 1'b0;
      r_ovf1 <= 1'b0;
    end else begin
      if (valid_in0 && r_full0) r_ovf0 <= 1'b1;
      if (valid_in1 && r_full1) r_ovf1 <= 1'b1;
    end
  end
  assign ovf0 = r_ovf0;
  assign ovf1 = r_ovf1;
`endif
endmodule

// File: tb/tb_merge_2x1_fifo.sv
// tb_merge_2x1_fifo: randomized and directed stimulus checked against a queue-based reference model.
module tb_merge_2x1_fifo;
  localparam int W = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] data_in0 = '0, data_in1 = '0;
  logic valid_in0 = 1'b1, valid_in1 = 1'b1, ready_in = 1'b1;
  logic full0, full1, valid_out;
  logic [W-1:0] data_out;
  logic ovf0, ovf1;
  logic m_ovf0, m_ovf1;
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic m_last, m_vld;
  logic [W-1:0] m_dout;
  int n_chk = 0;
  int n_pass = 0;
  merge_2x1_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .data_in0(data_in0), .valid_in0(valid_in0),
    .data_in1(data_in1), .valid_in1(valid_in1),
    .full0(full0), .full1(full1),
    .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in)
`ifdef MERGE_OVF_FLAG_EN
    , .ovf0(ovf0), .ovf1(ovf1)
`endif
  );
`ifndef MERGE_OVF_FLAG_EN
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_last = 1'b1;
    m_vld = 1'b0;
    m_dout = '0;
    m_ovf0 = 1'b0;
    m_ovf1 = 1'b0;
  endtask
  task automatic step(input logic v0, input logic [W-1:0] d0, input logic v1, input logic [W-1:0] d1, input logic rdy);
    int s0, s1;
    logic take1;
    valid_in0 = v0;
    data_in0 = d0;
    valid_in1 = v1;
    data_in1 = d1;
    ready_in = rdy;
    @(posedge clk);
    s0 = q0.size();
    s1 = q1.size();
    if ((!m_vld || rdy) && (s0 + s1 > 0)) begin
      take1 = (s0 > 0 && s1 > 0) ? !m_last : (s1 > 0);
      m_dout = take1 ? q1.pop_front() : q0.pop_front();
      m_vld = 1'b1;
      m_last = take1;
    end else if (!m_vld || rdy) begin
      m_vld = 1'b0;
    end
    if (v0) begin
      if (s0 < D) q0.push_back(d0);
      else m_ovf0 = 1'b1;
    end
    if (v1) begin
      if (s1 < D) q1.push_back(d1);
      else m_ovf1 = 1'b1;
    end
    #1;
    chk("data_out", data_out, m_dout);
    chk("valid_out", valid_out, m_vld);
    chk("full0", full0, q0.size() == D);
    chk("full1", full1, q1.size() == D);
`ifdef MERGE_OVF_FLAG_EN
    chk("ovf0", ovf0, m_ovf0);
    chk("ovf1", ovf1, m_ovf1);
`endif
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask
  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_data", data_out, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_full0", full0, 0);
      chk("rst_full1", full1, 0);
    end
    reset = 1'b0;
    step(1, 4'h1, 0, 0, 1);
    step(0, 0, 1, 4'h2, 1);
    chk("alt_1", data_out, 4'h1);
    step(1, 4'h3, 0, 0, 1);
    chk("alt_2", data_out, 4'h2);
    step(0, 0, 1, 4'h4, 1);
    chk("alt_3", data_out, 4'h3);
    step(1, 4'h5, 0, 0, 1);
    chk("alt_4", data_out, 4'h4);
    step(0, 0, 1, 4'h6, 1);
    chk("alt_5", data_out, 4'h5);
    step(0, 0, 0, 0, 1);
    chk("alt_6", data_out, 4'h6);
    chk("alt_6v", valid_out, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 4'hA, 1);
    chk("lat_k", valid_out, 0);
    step(0, 0, 0, 0, 1);
    chk("lat_v", valid_out, 1);
    chk("lat_d", data_out, 4'hA);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, W'(i), 0, 0, 0);
    chk("bp_full0", full0, 1);
    chk("bp_hold", data_out, 4'h0);
    chk("bp_hold_v", valid_out, 1);
    for (int i = 1; i < 5; i++) begin
      step(0, 0, 0, 0, 1);
      chk("bp_drain", data_out, i);
    end
    step(0, 0, 0, 0, 1);
    chk("bp_no5", valid_out, 0);
`ifdef MERGE_OVF_FLAG_EN
    chk("bp_ovf0", ovf0, 1);
`endif
    pulse_reset();
    step(1, 4'h7, 1, 4'h9, 0);
    step(1, 4'h8, 0, 0, 0);
    chk("arb_7", data_out, 4'h7);
    step(0, 0, 0, 0, 1);
    chk("arb_9", data_out, 4'h9);
    step(0, 0, 0, 0, 1);
    chk("arb_8", data_out, 4'h8);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, W'(i + 3), 0, 0, 0);
    chk("mr_full_pre", full0, 1);
    reset = 1'b1;
    #1;
    chk("mr_valid", valid_out, 0);
    chk("mr_full0", full0, 0);
    chk("mr_data", data_out, 0);
    valid_in0 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      chk("mr_nostale", valid_out, 0);
    end
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, W'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, W'($urandom_range(0, 15)),
           $urandom_range(0, 2) != 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
